// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: CHANNELS PWM outputs sharing one prescaled WIDTH-bit timebase.
// The timebase is edge-aligned (0..P, P+1 ticks) or centre-aligned (0..P..1, 2P ticks).
// Period, duty and mode sit in shadow registers. A reload happens only at a period
// boundary, so an output never sees a partial or glitched period.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                run enable; 0 holds the timebase at 0 and drives inactive levels
//   prescale          tick every prescale+1 clk (live, not shadowed)
//   period            top count P
//   duty              per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   center            0 edge-aligned, 1 centre-aligned
//   polarity          per-channel output inversion (live)
//   upd_req           pulse: reload shadows at the next boundary
//   pwm_out           registered PWM outputs
//   period_end        1-clk pulse per boundary
//   upd_done          1-clk pulse when shadows were reloaded at a boundary

// One channel: duty shadow plus the registered compare output.
module pwm_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             pol_i,
  output logic             pwm_o
);
  logic [WIDTH-1:0] duty_sh_q;
  logic             pwm_d;

  // While disabled the output sits at its inactive level, which is the polarity bit.
  assign pwm_d = en_i ? ((cnt_i < duty_sh_q) ^ pol_i) : pol_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh_q <= '0;
      pwm_o     <= 1'b0;
    end else begin
      if (load_i) duty_sh_q <= duty_i;
      pwm_o <= pwm_d;
    end
  end
endmodule

module pwm_multi_channel #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      center,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      upd_req,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_end,
  output logic                      upd_done
);
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;          // 0 = up, 1 = down
  logic                  pend_q, pend_d;
  logic [WIDTH-1:0]      period_sh_q;
  logic                  center_sh_q;
  logic                  tick, boundary, pend_eff, load;

  assign tick     = en && (pre_cnt_q == prescale);
  // A request arriving on the boundary cycle itself is honoured at that boundary.
  assign pend_eff = pend_q | upd_req;
  // Disabled: shadows follow the live inputs so a restart uses fresh values.
  assign load     = !en || (boundary && pend_eff);

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    boundary  = 1'b0;
    if (tick) begin
      pre_cnt_d = '0;
      if (!center_sh_q) begin
        if (cnt_q == period_sh_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if (!dir_q) begin
        if (cnt_q == period_sh_q) begin
          // With P<=1 there is no down leg. P=0 makes every tick a boundary.
          // P=1 gives the 2-tick period 0,1.
          if (period_sh_q <= WIDTH'(1)) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            dir_d = 1'b1;
            cnt_d = period_sh_q - WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        // Test <=1 rather than ==1 so the down leg can never underflow.
        if (cnt_q <= WIDTH'(1)) begin
          dir_d    = 1'b0;
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    pend_d = (boundary && pend_eff) ? 1'b0 : pend_eff;
    if (!en) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
      dir_d     = 1'b0;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      pend_q      <= 1'b0;
      period_sh_q <= '0;
      center_sh_q <= 1'b0;
      period_end  <= 1'b0;
      upd_done    <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      period_end <= boundary;
      upd_done   <= boundary && pend_eff;
      if (load) begin
        period_sh_q <= period;
        center_sh_q <= center;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_chan #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .load_i (load),
      .cnt_i  (cnt_q),
      .duty_i (duty[i*WIDTH +: WIDTH]),
      .pol_i  (polarity[i]),
      .pwm_o  (pwm_out[i])
    );
  end
endmodule
